// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-stage controller.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int unsigned RD_W       = 5;
  localparam logic [1:0]  ALIGN_MASK = 2'b11;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Access watchdog: counts cycles while enabled and flags the last allowed cycle.
module mem_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Fires during the TIMEOUT_CYC-th enabled cycle so the FSM can leave on that edge.
  assign expired = en && (cnt_q == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: data-memory request/grant/response handshake and MEM/WB D-side.
// Define MEM_TIMEOUT_EN to abort accesses that sit in REQ/WAIT for TIMEOUT_CYC cycles.
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [RD_W-1:0]   ex_rd,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_reg_write,
  input  logic              ex_mem_to_reg,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic [RD_W-1:0]   wb_rd,
  output logic              wb_reg_write,
  output logic              mem_err
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [RD_W-1:0]   rd_q, rd_d;
  logic              reg_write_q, reg_write_d, mem_to_reg_q, mem_to_reg_d;
  logic              is_store_q, is_store_d, err_q, err_d;
  logic              req_q, req_d, we_q, we_d;
  logic              memop, misaligned, timeout;

  assign memop      = ex_valid && (ex_mem_read || ex_mem_write);
  assign misaligned = (ex_alu_result[1:0] & ALIGN_MASK) != 2'b00;

`ifdef MEM_TIMEOUT_EN
  logic ctr_clear, ctr_en;

  assign ctr_clear = (state_q == IDLE) && memop && !misaligned;
  assign ctr_en    = (state_q == REQ) || (state_q == WAIT);

  mem_timeout_ctr #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (ctr_clear),
    .en     (ctr_en),
    .expired(timeout)
  );
`else
  localparam int unsigned unused_timeout_cyc = TIMEOUT_CYC;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    rd_d         = rd_q;
    reg_write_d  = reg_write_q;
    mem_to_reg_d = mem_to_reg_q;
    is_store_d   = is_store_q;
    err_d        = err_q;
    req_d        = req_q;
    we_d         = we_q;
    stall        = 1'b0;
    wb_valid     = 1'b0;
    wb_data      = ex_alu_result;
    wb_rd        = ex_rd;
    wb_reg_write = 1'b0;
    mem_err      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (memop) begin
          stall        = 1'b1;
          addr_d       = ex_alu_result;
          wdata_d      = ex_store_data;
          rd_d         = ex_rd;
          reg_write_d  = ex_reg_write;
          mem_to_reg_d = ex_mem_to_reg;
          is_store_d   = ex_mem_write;
          if (misaligned) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            req_d   = 1'b1;
            we_d    = ex_mem_write;
            state_d = REQ;
          end
        end else begin
          wb_valid     = ex_valid;
          wb_reg_write = ex_valid && ex_reg_write;
        end
      end
      REQ: begin
        stall = 1'b1;
        // A completing handshake beats a coincident timeout.
        if (mem_gnt && (is_store_q || mem_rvalid)) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          state_d = DONE;
          if (!is_store_q) begin
            rdata_d = mem_rdata;
          end
        end else if (timeout) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          err_d   = 1'b1;
          state_d = DONE;
        end else if (mem_gnt) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (mem_rvalid) begin
          rdata_d = mem_rdata;
          state_d = DONE;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        wb_valid     = 1'b1;
        wb_rd        = rd_q;
        wb_data      = mem_to_reg_q ? rdata_q : addr_q;
        wb_reg_write = reg_write_q && !err_q;
        mem_err      = err_q;
        err_d        = 1'b0;
        state_d      = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      rd_q         <= '0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      is_store_q   <= 1'b0;
      err_q        <= 1'b0;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      rd_q         <= rd_d;
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      is_store_q   <= is_store_d;
      err_q        <= err_d;
      req_q        <= req_d;
      we_q         <= we_d;
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: directed cases, a reset-in-WAIT case, then random traffic.
module tb_mem_stage_ctrl;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned TCYC = 4;
  localparam int unsigned MAXD = 1;
`else
  localparam int unsigned TCYC = 16;
  localparam int unsigned MAXD = 3;
`endif

  logic        clk, reset;
  logic        ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg;
  logic [31:0] ex_alu_result, ex_store_data;
  logic [4:0]  ex_rd;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        stall, wb_valid, wb_reg_write, mem_err;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;

  mem_stage_ctrl #(
    .DATA_W(32),
    .TIMEOUT_CYC(TCYC)
  ) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .stall(stall), .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
    .wb_reg_write(wb_reg_write), .mem_err(mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    bit          chk_data;
    logic [4:0]  rd;
    bit          rw;
    bit          err;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    bit          we;
    logic [31:0] wdata;
  } req_t;

  exp_t        sbq[$];
  req_t        reqq[$];
  logic [31:0] rdq[$];
  int          checks = 0;
  int          errors = 0;
  int          fixed_gnt = -1;
  int          fixed_rv = -1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] pop_rd();
    if (rdq.size() == 0) return 32'hBAD0_BAD0;
    return rdq.pop_front();
  endfunction

  // Monitor: every presented write-back retires the oldest expected instruction.
  always @(negedge clk) begin
    exp_t e;
    if (reset && wb_valid) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb_unexpected: got wb_data %h expected no write-back", wb_data);
      end else begin
        e = sbq.pop_front();
        if (e.chk_data) chk("wb_data", wb_data, e.data);
        chk("wb_rd", 32'(wb_rd), 32'(e.rd));
        chk("wb_reg_write", 32'(wb_reg_write), 32'(e.rw));
        chk("mem_err", 32'(mem_err), 32'(e.err));
      end
    end
  end

  // Memory responder: grants after a delay, returns load data, injects ignored noise when idle.
  initial begin
    int   gcnt, rcnt;
    bit   pending;
    req_t r;
    gcnt = -1;
    rcnt = 0;
    pending = 1'b0;
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata = $urandom;
      if (!reset) begin
        pending = 1'b0;
        gcnt = -1;
        mem_gnt = 1'($urandom);
        mem_rvalid = 1'($urandom);
      end else if (pending) begin
        if (rcnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata = pop_rd();
          pending = 1'b0;
        end else begin
          rcnt--;
        end
      end else if (mem_req) begin
        if (gcnt < 0) gcnt = (fixed_gnt >= 0) ? fixed_gnt : int'($urandom_range(0, MAXD));
        if (gcnt == 0) begin
          gcnt = -1;
          mem_gnt = 1'b1;
          if (reqq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_req: got request at %h expected none", mem_addr);
          end else begin
            r = reqq.pop_front();
            chk("mem_addr", mem_addr, r.addr);
            chk("mem_we", 32'(mem_we), 32'(r.we));
            if (r.we) chk("mem_wdata", mem_wdata, r.wdata);
          end
          if (!mem_we) begin
            rcnt = (fixed_rv >= 0) ? fixed_rv : int'($urandom_range(0, MAXD));
            if (rcnt == 0) begin
              mem_rvalid = 1'b1;
              mem_rdata = pop_rd();
            end else begin
              pending = 1'b1;
              rcnt--;
            end
          end
        end else begin
          gcnt--;
        end
      end else begin
        gcnt = -1;
        if ($urandom_range(0, 7) == 0) begin
          mem_gnt = 1'($urandom);
          mem_rvalid = 1'($urandom);
        end
      end
    end
  end

  // Presents one instruction, records its expected outcome, and waits until EX/MEM advances.
  task automatic issue(input bit v, input bit rdb, input bit wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] rd, input bit rw,
                       input bit m2r, input logic [31:0] ld, input bit tmo,
                       output int stalls);
    exp_t e;
    req_t r;
    bit   memop, mis, done;
    ex_valid = v;
    ex_mem_read = rdb;
    ex_mem_write = wr;
    ex_alu_result = a;
    ex_store_data = wd;
    ex_rd = rd;
    ex_reg_write = rw;
    ex_mem_to_reg = m2r;
    memop = v && (rdb || wr);
    mis = (a[1:0] != 2'b00);
    e.rd = rd;
    if (!memop) begin
      e.data = a;
      e.chk_data = 1'b1;
      e.rw = rw;
      e.err = 1'b0;
      if (v) sbq.push_back(e);
    end else begin
      e.err = mis || tmo;
      e.rw = rw && !e.err;
      if (wr) begin
        e.data = a;
        e.chk_data = !m2r;
      end else if (m2r) begin
        e.data = ld;
        e.chk_data = !e.err;
      end else begin
        e.data = a;
        e.chk_data = 1'b1;
      end
      if (!mis && !tmo) begin
        r.addr = a;
        r.we = wr;
        r.wdata = wd;
        reqq.push_back(r);
        if (!wr) rdq.push_back(ld);
      end
      sbq.push_back(e);
    end
    stalls = 0;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (stall) stalls++;
      else done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL stall_release: got stall held 200 cycles expected release");
    end
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1);
  end

  initial begin
    int          st;
    int          k;
    bit          v, rdb, wr, rw, m2r;
    logic [31:0] a, wd, ld;
    reset = 1'b0;
    ex_valid = 1'b0;
    ex_mem_read = 1'b0;
    ex_mem_write = 1'b0;
    ex_reg_write = 1'b0;
    ex_mem_to_reg = 1'b0;
    ex_alu_result = '0;
    ex_store_data = '0;
    ex_rd = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // ALU pass-through, zero latency.
    issue(1, 0, 0, 32'h0000_1234, 32'h0, 5'd5, 1, 0, 32'h0, 0, st);
    chk("alu_stalls", 32'(st), 32'd0);

    // Load: grant 2 cycles after request, data one cycle after grant.
    fixed_gnt = 2;
    fixed_rv = 1;
    issue(1, 1, 0, 32'h0000_0100, 32'h0, 5'd7, 1, 1, 32'hDEAD_BEEF, 0, st);
    chk("load_stalls", 32'(st), 32'd5);

    // Store granted on the first REQ cycle.
    fixed_gnt = 0;
    issue(1, 0, 1, 32'h0000_0200, 32'hA5A5_A5A5, 5'd3, 0, 0, 32'h0, 0, st);
    chk("store_stalls", 32'(st), 32'd2);
    chk("store_req_drop", 32'(mem_req), 32'd0);

    // Misaligned load never requests.
    issue(1, 1, 0, 32'h0000_0102, 32'h0, 5'd9, 1, 1, 32'h0, 0, st);
    chk("misalign_stalls", 32'(st), 32'd1);
    chk("misalign_no_req", 32'(mem_req), 32'd0);

    // Reset while waiting for load data.
    fixed_gnt = 0;
    fixed_rv = 5;
    ex_valid = 1'b1;
    ex_mem_read = 1'b1;
    ex_mem_write = 1'b0;
    ex_alu_result = 32'h0000_0300;
    ex_rd = 5'd11;
    ex_reg_write = 1'b1;
    ex_mem_to_reg = 1'b1;
    reqq.push_back('{addr: 32'h300, we: 1'b0, wdata: 32'h0});
    rdq.push_back(32'h1111_2222);
    repeat (3) @(negedge clk);
    chk("wait_stall", 32'(stall), 32'd1);
    #2;
    ex_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("arst_mem_req", 32'(mem_req), 32'd0);
    chk("arst_idle_stall", 32'(stall), 32'd0);
    chk("arst_wb_valid", 32'(wb_valid), 32'd0);
    repeat (3) @(negedge clk);
    sbq.delete();
    reqq.delete();
    rdq.delete();
    reset = 1'b1;
    @(posedge clk);
    #1;
    fixed_gnt = -1;
    fixed_rv = -1;
    issue(1, 0, 0, 32'hCAFE_0001, 32'h0, 5'd12, 1, 0, 32'h0, 0, st);
    chk("post_rst_stalls", 32'(st), 32'd0);

`ifdef MEM_TIMEOUT_EN
    // Never granted: abort after TCYC cycles in REQ.
    fixed_gnt = 100;
    issue(1, 0, 1, 32'h0000_0400, 32'h1234_5678, 5'd1, 0, 0, 32'h0, 1, st);
    chk("tmo_stalls", 32'(st), 32'(1 + TCYC));
    chk("tmo_req_drop", 32'(mem_req), 32'd0);
    // Grant on the last allowed cycle wins over the timeout.
    fixed_gnt = int'(TCYC) - 1;
    issue(1, 0, 1, 32'h0000_0404, 32'h8765_4321, 5'd2, 1, 0, 32'h0, 0, st);
    chk("tmo_edge_stalls", 32'(st), 32'(1 + TCYC));
    fixed_gnt = -1;
`endif

    for (int n = 0; n < 300; n++) begin
      k = int'($urandom_range(0, 3));
      v = ($urandom_range(0, 7) != 0);
      rdb = (k == 1) || (k == 3);
      wr = (k == 2) || (k == 3);
      a = $urandom;
      if ($urandom_range(0, 5) != 0) a[1:0] = 2'b00;
      wd = $urandom;
      ld = $urandom;
      rw = 1'($urandom);
      m2r = rdb && !wr && 1'($urandom);
      issue(v, rdb, wr, a, wd, 5'($urandom), rw, m2r, ld, 0, st);
    end

    ex_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    chk("req_drained", 32'(reqq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
